pipeline_stall_unit: RTL and testbench

- Detects hazards that result forwarding cannot resolve in the 5-stage pipeline:
  - load-use dependencies;
  - taken-branch redirects;
  - reads of a register still owned by the multi-cycle divider.
- Drives the stall and flush controls of the IF/ID/EX pipeline registers.
- Tracks the divider with a small busy/done state machine and latency counter, and pulses the divider write-back strobe.
- Sits beside the forwarding unit: forwarding supplies ready results; this block holds consumers back until results exist.

---
 rtl/pipeline_stall_unit.sv | 161 ++++++++++++++++
 tb/tb_pipeline_stall_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_unit.sv
// -----------------------------------------------------------------------------
// pipeline_stall_unit
//
// Hazard detection for the 5-stage pipeline. Holds back consumers whose
// operands forwarding cannot supply yet, and flushes wrong-path work on a
// taken branch:
//   - load-use: the load in EX has not yet read memory.
//   - divider:  a register is still owned by the multi-cycle divider.
//   - branch:   a taken branch/jump resolved in EX redirects fetch.
//
// Optional feature macro: HAZARD_DIV_EN
//   defined   -> divider FSM (IDLE/BUSY/DONE), latency counter, divider
//                hazard term and divider outputs are built.
//   undefined -> load-use and branch logic only. DivBusy, DivWbValid and
//                DivWbRd are tied to 0, and DivStartEx is ignored.
//
// Parameters:
//   DIV_LAT  divider latency, EX issue to result ready (2..255)
//   CNT_W    latency counter width (2**CNT_W > DIV_LAT)
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-high reset
//   MemReadEx   in   EX instruction is a load
//   RD_Ex       in   EX destination register
//   RS1D, RS2D  in   ID source registers
//   RD_D        in   ID destination register
//   DivStartEx  in   divide instruction in EX this cycle
//   PCSrcEx     in   taken branch/jump resolved in EX
//   StallF      out  hold the PC
//   StallD      out  hold the IF/ID register
//   FlushD      out  clear the IF/ID register
//   FlushEx     out  clear the ID/EX register (bubble)
//   DivBusy     out  divider occupied
//   DivWbValid  out  one-cycle divider write-back strobe
//   DivWbRd     out  divider destination register
// -----------------------------------------------------------------------------
module pipeline_stall_unit #(
  parameter int unsigned DIV_LAT = 8,
  parameter int unsigned CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       MemReadEx,
  input  logic [4:0] RD_Ex,
  input  logic [4:0] RS1D,
  input  logic [4:0] RS2D,
  input  logic [4:0] RD_D,
  input  logic       DivStartEx,
  input  logic       PCSrcEx,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushD,
  output logic       FlushEx,
  output logic       DivBusy,
  output logic       DivWbValid,
  output logic [4:0] DivWbRd
);

  // Counter load value: the first BUSY cycle counts as one, so a result is
  // ready after exactly DIV_LAT BUSY cycles.
  localparam logic [CNT_W-1:0] LP_CNT_INIT = CNT_W'(DIV_LAT - 1);

  logic w_lu;
  logic w_dh;

  // Load-use: x0 is never a real dependency.
  assign w_lu = MemReadEx && (RD_Ex != 5'd0) &&
                ((RD_Ex == RS1D) || (RD_Ex == RS2D));

`ifdef HAZARD_DIV_EN

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

  div_state_e       r_state;
  div_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [4:0]       r_div_rd;
  logic [4:0]       w_div_rd_nxt;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_div_rd_nxt = r_div_rd;
    case (r_state)
      // DONE accepts a new divide directly, so back-to-back divides skip IDLE.
      S_IDLE, S_DONE: begin
        if (DivStartEx) begin
          w_state_nxt  = S_BUSY;
          w_cnt_nxt    = LP_CNT_INIT;
          w_div_rd_nxt = RD_Ex;
        end else begin
          w_state_nxt  = S_IDLE;
        end
      end
      // DivStartEx cannot legally arrive here; it is ignored.
      S_BUSY: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt   = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_div_rd <= 5'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_div_rd <= w_div_rd_nxt;
    end
  end

  // RD_D term stops a younger writer of the same register from completing
  // before the divide and then being overwritten by the stale divide result.
  assign w_dh = (r_state == S_BUSY) && (r_div_rd != 5'd0) &&
                ((RS1D == r_div_rd) || (RS2D == r_div_rd) ||
                 (RD_D == r_div_rd));

  assign DivBusy    = (r_state == S_BUSY);
  assign DivWbValid = (r_state == S_DONE);
  assign DivWbRd    = r_div_rd;

`else

  logic w_unused_div;

  assign w_dh       = 1'b0;
  assign DivBusy    = 1'b0;
  assign DivWbValid = 1'b0;
  assign DivWbRd    = 5'd0;

  assign w_unused_div = ^{DivStartEx, RD_D, LP_CNT_INIT};

`endif

  // A taken branch wins: the stalled ID instruction is on the wrong path and
  // is flushed, so fetch must move on to the redirect target.
  assign StallF  = (w_lu || w_dh) && !PCSrcEx;
  assign StallD  = (w_lu || w_dh) && !PCSrcEx;
  assign FlushD  = PCSrcEx;
  assign FlushEx = w_lu || w_dh || PCSrcEx;

endmodule

// File: tb/tb_pipeline_stall_unit.sv
// -----------------------------------------------------------------------------
// tb_pipeline_stall_unit
//
// Directed bench for pipeline_stall_unit (DIV_LAT=8). Each step drives the
// inputs just after a rising edge, queues the expected output vector, and
// compares at the following falling edge. The divider section follows the
// build: with HAZARD_DIV_EN the FSM timing is checked, without it the divider
// outputs must stay 0.
// -----------------------------------------------------------------------------
module tb_pipeline_stall_unit;

  typedef struct {
    string      tag;
    logic [10:0] vec;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       MemReadEx;
  logic [4:0] RD_Ex;
  logic [4:0] RS1D;
  logic [4:0] RS2D;
  logic [4:0] RD_D;
  logic       DivStartEx;
  logic       PCSrcEx;
  logic       StallF;
  logic       StallD;
  logic       FlushD;
  logic       FlushEx;
  logic       DivBusy;
  logic       DivWbValid;
  logic [4:0] DivWbRd;

  logic [10:0] obs;
  exp_t        sb_q[$];
  int          n_total;
  int          n_pass;

  pipeline_stall_unit #(
    .DIV_LAT (8),
    .CNT_W   (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .MemReadEx  (MemReadEx),
    .RD_Ex      (RD_Ex),
    .RS1D       (RS1D),
    .RS2D       (RS2D),
    .RD_D       (RD_D),
    .DivStartEx (DivStartEx),
    .PCSrcEx    (PCSrcEx),
    .StallF     (StallF),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .FlushEx    (FlushEx),
    .DivBusy    (DivBusy),
    .DivWbValid (DivWbValid),
    .DivWbRd    (DivWbRd)
  );

  assign obs = {StallF, StallD, FlushD, FlushEx, DivBusy, DivWbValid, DivWbRd};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1);
  end

  function automatic logic [10:0] mk(input logic sf, input logic sd,
                                     input logic fd, input logic fe,
                                     input logic busy, input logic wbv,
                                     input logic [4:0] rd);
    return {sf, sd, fd, fe, busy, wbv, rd};
  endfunction

  task automatic push_exp(input string tag, input logic [10:0] vec);
    sb_q.push_back('{tag: tag, vec: vec});
  endtask

  task automatic sample();
    exp_t e;
    n_total++;
    if (sb_q.size() == 0) begin
      $error("FAIL sb_empty: observed %h with no expected entry", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.vec) n_pass++;
      else $error("FAIL %s: observed %h required %h", e.tag, obs, e.vec);
    end
  endtask

  task automatic drive(input logic mr, input logic [4:0] rde,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rdd, input logic ds, input logic pc);
    MemReadEx  = mr;
    RD_Ex      = rde;
    RS1D       = rs1;
    RS2D       = rs2;
    RD_D       = rdd;
    DivStartEx = ds;
    PCSrcEx    = pc;
  endtask

  // One clock cycle: drive after the edge, compare mid-cycle.
  task automatic step(input string tag, input logic mr, input logic [4:0] rde,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rdd, input logic ds, input logic pc,
                      input logic [10:0] vec);
    @(posedge clk);
    #1;
    drive(mr, rde, rs1, rs2, rdd, ds, pc);
    push_exp(tag, vec);
    @(negedge clk);
    sample();
  endtask

  initial begin
    logic [10:0] zero;
    zero    = 11'd0;
    n_total = 0;
    n_pass  = 0;
    rst     = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

    // Reset state.
    #3;
    push_exp("reset", zero);
    sample();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Load-use and branch.
    step("lu_rs2",         1, 5'd5, 5'd0, 5'd5, 5'd0, 0, 0, mk(1,1,0,1,0,0,5'd0));
    step("lu_release",     0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, zero);
    step("lu_rs1",         1, 5'd5, 5'd5, 5'd0, 5'd0, 0, 0, mk(1,1,0,1,0,0,5'd0));
    step("lu_x0",          1, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, zero);
    step("no_load",        0, 5'd5, 5'd0, 5'd5, 5'd0, 0, 0, zero);
    step("branch_over_lu", 1, 5'd5, 5'd0, 5'd5, 5'd0, 0, 1, mk(0,0,1,1,0,0,5'd0));
    step("branch_only",    0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 1, mk(0,0,1,1,0,0,5'd0));

`ifdef HAZARD_DIV_EN
    // Divide issued with RD_Ex=9; the issue cycle itself is still IDLE.
    step("div_issue", 0, 5'd9, 5'd0, 5'd0, 5'd0, 1, 0, zero);
    for (int i = 0; i < 8; i++) begin
      logic [4:0]  rs1;
      logic [4:0]  rdd;
      logic        pc;
      logic [10:0] vec;
      rs1 = (i == 5) ? 5'd0 : ((i == 6) ? 5'd3 : 5'd9);
      rdd = (i == 5) ? 5'd9 : 5'd0;
      pc  = (i == 4);
      if (i == 4)      vec = mk(0,0,1,1,1,0,5'd9);
      else if (i == 6) vec = mk(0,0,0,0,1,0,5'd9);
      else             vec = mk(1,1,0,1,1,0,5'd9);
      step($sformatf("div_busy%0d", i), 0, 5'd0, rs1, 5'd0, rdd, 0, pc, vec);
    end
    // DONE: dependent released, strobe up, and a new divide captured at once.
    step("div_done_b2b", 0, 5'd12, 5'd9, 5'd0, 5'd0, 1, 0, mk(0,0,0,0,0,1,5'd9));
    step("b2b_busy1",    0, 5'd0,  5'd0, 5'd0, 5'd0, 0, 0, mk(0,0,0,0,1,0,5'd12));
    step("b2b_rs2",      0, 5'd0,  5'd0, 5'd12,5'd0, 0, 0, mk(1,1,0,1,1,0,5'd12));
    step("b2b_busy3",    0, 5'd0,  5'd0, 5'd0, 5'd0, 0, 0, mk(0,0,0,0,1,0,5'd12));
`else
    // Divider not built: divide requests change nothing.
    step("div_issue", 0, 5'd9, 5'd0, 5'd0, 5'd0, 1, 0, zero);
    for (int i = 0; i < 8; i++) begin
      step($sformatf("div_off%0d", i), 0, 5'd0, 5'd9, 5'd0, 5'd9, 0, 0, zero);
    end
    step("div_off_b2b", 0, 5'd12, 5'd9, 5'd0, 5'd0, 1, 0, zero);
    step("div_off_lu",  1, 5'd12, 5'd0, 5'd12, 5'd0, 0, 0, mk(1,1,0,1,0,0,5'd0));
    step("div_off_br",  1, 5'd12, 5'd12, 5'd0, 5'd0, 0, 1, mk(0,0,1,1,0,0,5'd0));
    step("div_off_idle",0, 5'd0,  5'd0, 5'd0, 5'd0, 0, 0, zero);
`endif

    // Asynchronous reset mid-cycle, away from any clock edge.
    #1;
    rst = 1'b1;
    #1;
    push_exp("rst_async", zero);
    sample();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // No write-back strobe may follow the discarded divide.
    for (int i = 0; i < 12; i++) begin
      step($sformatf("post_rst%0d", i), 0, 5'd0, 5'd12, 5'd0, 5'd0, 0, 0, zero);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
